// File: rtl/wb_arbiter_if.sv
// Pipelined Wishbone link between one master and one slave.
// The master modport drives the request side; the slave modport drives responses.
interface wb_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 30,
  parameter int SelWidth  = DataWidth / 8
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [SelWidth-1:0]  sel;
  logic [DataWidth-1:0] data_m;
  logic [DataWidth-1:0] data_s;
  logic                 ack;
  logic                 err;
  logic                 stall;

  modport master (
    output cyc, stb, we, addr, sel, data_m,
    input  data_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, addr, sel, data_m,
    output data_s, ack, err, stall
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter: round-robin grant held for a
// whole cyc, 4-bit outstanding-request limit, and a watchdog that aborts hung cycles.
module wb_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 30,
  parameter int SelWidth      = DataWidth / 8,
  parameter int TimeoutCycles = 255
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s
);

  localparam int TimerWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [3:0] MaxOutstanding = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    ABORT
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;          // 1: m1 held the bus most recently
  logic                  abort_m1_q, abort_m1_d;  // owner of the aborted cycle
  logic [3:0]            outstanding_q, outstanding_d;
  logic [TimerWidth-1:0] timer_q, timer_d;

  logic                 granted;
  logic                 sel_m1;
  logic                 g_cyc, g_stb, g_we, other_cyc;
  logic [AddrWidth-1:0] g_addr;
  logic [SelWidth-1:0]  g_sel;
  logic [DataWidth-1:0] g_data_m;
  logic                 resp, timeout, hold, stb_out, accept, retire;

  assign granted   = (state_q == GRANT0) || (state_q == GRANT1);
  assign sel_m1    = (state_q == GRANT1);
  assign g_cyc     = sel_m1 ? m1.cyc    : m0.cyc;
  assign g_stb     = sel_m1 ? m1.stb    : m0.stb;
  assign g_we      = sel_m1 ? m1.we     : m0.we;
  assign g_addr    = sel_m1 ? m1.addr   : m0.addr;
  assign g_sel     = sel_m1 ? m1.sel    : m0.sel;
  assign g_data_m  = sel_m1 ? m1.data_m : m0.data_m;
  assign other_cyc = sel_m1 ? m0.cyc    : m1.cyc;

  // A master that drops cyc leaves normally, so the watchdog only fires while cyc is held.
  assign resp    = s.ack | s.err;
  assign timeout = granted && g_cyc && (TimeoutCycles != 0) &&
                   (timer_q == TimerWidth'(TimeoutCycles));
  assign hold    = (outstanding_q == MaxOutstanding) || timeout;
  assign stb_out = granted && g_stb && !hold;
  assign accept  = stb_out && !s.stall;
  assign retire  = resp && (outstanding_q != 4'd0);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    s.cyc     = 1'b0;
    s.stb     = 1'b0;
    s.we      = 1'b0;
    s.addr    = '0;
    s.sel     = '0;
    s.data_m  = '0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.stall  = 1'b1;
    m0.data_s = '0;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.stall  = 1'b1;
    m1.data_s = '0;
    if (granted) begin
      s.cyc    = g_cyc;
      s.stb    = stb_out;
      s.we     = g_we;
      s.addr   = g_addr;
      s.sel    = g_sel;
      s.data_m = g_data_m;
      if (sel_m1) begin
        m1.ack    = s.ack & ~timeout;
        m1.err    = s.err | timeout;
        m1.stall  = s.stall | hold;
        m1.data_s = s.data_s;
      end else begin
        m0.ack    = s.ack & ~timeout;
        m0.err    = s.err | timeout;
        m0.stall  = s.stall | hold;
        m0.data_s = s.data_s;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    abort_m1_d    = abort_m1_q;
    outstanding_d = outstanding_q;
    timer_d       = timer_q;
    case (state_q)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_q)) state_d = GRANT0;
        else if (m1.cyc)                   state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!g_cyc) begin
          // Responses still in flight are abandoned with the cycle.
          last_d        = sel_m1;
          outstanding_d = 4'd0;
          timer_d       = '0;
          if (other_cyc) state_d = sel_m1 ? GRANT0 : GRANT1;
          else           state_d = IDLE;
        end else if (timeout) begin
          abort_m1_d    = sel_m1;
          outstanding_d = 4'd0;
          timer_d       = '0;
          state_d       = ABORT;
        end else begin
          if (accept && !retire)      outstanding_d = outstanding_q + 4'd1;
          else if (!accept && retire) outstanding_d = outstanding_q - 4'd1;
          // Counting from the accepting cycle puts the abort exactly TimeoutCycles later.
          if ((TimeoutCycles != 0) && (outstanding_d != 4'd0) && !resp)
            timer_d = timer_q + TimerWidth'(1);
          else
            timer_d = '0;
        end
      end
      ABORT: begin
        if (!(abort_m1_q ? m1.cyc : m0.cyc)) begin
          last_d = abort_m1_q;
          if (abort_m1_q ? m0.cyc : m1.cyc) state_d = abort_m1_q ? GRANT0 : GRANT1;
          else                              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      abort_m1_q    <= 1'b0;
      outstanding_q <= 4'd0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      abort_m1_q    <= abort_m1_d;
      outstanding_q <= outstanding_d;
      timer_q       <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: dut_a uses the default watchdog, dut_b a short
// 8-cycle watchdog. Inputs change just after the rising edge, outputs are read on the falling edge.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 4;
  localparam logic [AW-1:0] ADDR0 = 30'h100;
  localparam logic [AW-1:0] ADDR1 = 30'h200;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.DataWidth(DW), .AddrWidth(AW), .SelWidth(SW)) a_m0 (), a_m1 (), a_s ();
  wb_arbiter_if #(.DataWidth(DW), .AddrWidth(AW), .SelWidth(SW)) b_m0 (), b_m1 (), b_s ();

  wb_arbiter #(.DataWidth(DW), .AddrWidth(AW), .SelWidth(SW), .TimeoutCycles(255)) dut_a (
    .clk(clk), .reset(reset), .m0(a_m0), .m1(a_m1), .s(a_s)
  );

  wb_arbiter #(.DataWidth(DW), .AddrWidth(AW), .SelWidth(SW), .TimeoutCycles(8)) dut_b (
    .clk(clk), .reset(reset), .m0(b_m0), .m1(b_m1), .s(b_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_m0.cyc = 0; a_m0.stb = 0; a_m0.we = 0; a_m0.addr = ADDR0; a_m0.sel = 4'hF; a_m0.data_m = 32'h0000_0A0A;
    a_m1.cyc = 0; a_m1.stb = 0; a_m1.we = 0; a_m1.addr = ADDR1; a_m1.sel = 4'hF; a_m1.data_m = 32'h0000_1B1B;
    b_m0.cyc = 0; b_m0.stb = 0; b_m0.we = 0; b_m0.addr = ADDR0; b_m0.sel = 4'hF; b_m0.data_m = 32'h0000_2C2C;
    b_m1.cyc = 0; b_m1.stb = 0; b_m1.we = 0; b_m1.addr = ADDR1; b_m1.sel = 4'hF; b_m1.data_m = 32'h0000_3D3D;
    a_s.data_s = '0; a_s.ack = 0; a_s.err = 0; a_s.stall = 0;
    b_s.data_s = '0; b_s.ack = 0; b_s.err = 0; b_s.stall = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    a_m0.cyc = 1; a_m1.cyc = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_s.stb, a_m0.stall, a_m1.stall, a_m0.ack, a_m1.ack} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 001100",
               {a_s.cyc, a_s.stb, a_m0.stall, a_m1.stall, a_m0.ack, a_m1.ack});
    end
    checks++;
    if (a_s.addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", a_s.addr); end
    tick();
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    a_m0.cyc = 1; a_m0.stb = 1; a_m0.addr = 30'h10;
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m0.stall} !== 2'b01) begin
      errors++; $display("FAIL single_req_cycle: got %b expected 01", {a_s.cyc, a_m0.stall});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_s.stb, a_s.we, a_m0.stall, a_m1.stall} !== 5'b11001) begin
      errors++; $display("FAIL single_grant: got %b expected 11001",
                         {a_s.cyc, a_s.stb, a_s.we, a_m0.stall, a_m1.stall});
    end
    checks++;
    if (a_s.addr !== 30'h10) begin errors++; $display("FAIL single_addr: got %h expected 10", a_s.addr); end
    tick();
    a_m0.stb = 0;
    @(negedge clk);
    checks++;
    if ({a_m0.ack, a_m1.stall} !== 2'b01) begin
      errors++; $display("FAIL single_wait: got %b expected 01", {a_m0.ack, a_m1.stall});
    end
    tick();
    a_s.ack = 1; a_s.data_s = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({a_m0.ack, a_m0.err, a_m1.ack, a_m1.stall} !== 4'b1001) begin
      errors++; $display("FAIL single_ack: got %b expected 1001", {a_m0.ack, a_m0.err, a_m1.ack, a_m1.stall});
    end
    checks++;
    if (a_m0.data_s !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_data: got %h expected deadbeef", a_m0.data_s);
    end
    checks++;
    if (a_m1.data_s !== '0) begin errors++; $display("FAIL single_other_data: got %h expected 0", a_m1.data_s); end
    tick();
    a_s.ack = 0; a_s.data_s = '0; a_m0.cyc = 0;
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m0.ack, a_m1.stall} !== 3'b001) begin
      errors++; $display("FAIL single_drop: got %b expected 001", {a_s.cyc, a_m0.ack, a_m1.stall});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m0.stall, a_m1.stall} !== 3'b011) begin
      errors++; $display("FAIL single_idle: got %b expected 011", {a_s.cyc, a_m0.stall, a_m1.stall});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_m0.cyc = 1; a_m1.cyc = 1;
    @(negedge clk);
    checks++;
    if (a_s.cyc !== 1'b0) begin errors++; $display("FAIL simul_latency: got %b expected 0", a_s.cyc); end
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_s.addr, a_m0.stall, a_m1.stall} !== {1'b1, ADDR0, 2'b01}) begin
      errors++; $display("FAIL simul_first_m0: got cyc=%b addr=%h stalls=%b expected cyc=1 addr=%h stalls=01",
                         a_s.cyc, a_s.addr, {a_m0.stall, a_m1.stall}, ADDR0);
    end
    tick();
    a_m0.cyc = 0;
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m1.stall} !== 2'b01) begin
      errors++; $display("FAIL simul_drop: got %b expected 01", {a_s.cyc, a_m1.stall});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_s.addr, a_m0.stall, a_m1.stall} !== {1'b1, ADDR1, 2'b10}) begin
      errors++; $display("FAIL simul_handover_m1: got cyc=%b addr=%h stalls=%b expected cyc=1 addr=%h stalls=10",
                         a_s.cyc, a_s.addr, {a_m0.stall, a_m1.stall}, ADDR1);
    end
    tick();
    a_m1.cyc = 0;
    tick();
  endtask

  task automatic test_round_robin();
    int              acks0;
    int              acks1;
    logic            exp1;
    logic [AW-1:0]   exp_addr;
    logic [1:0]      exp_stalls;
    do_reset();
    a_m0.cyc = 1; a_m1.cyc = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp1       = (k % 2) == 1;
      exp_addr   = exp1 ? ADDR1 : ADDR0;
      exp_stalls = exp1 ? 2'b10 : 2'b01;
      acks0 = 0; acks1 = 0;
      a_m0.cyc = 1; a_m1.cyc = 1;
      // Three strobes, each acked the cycle after acceptance, then one cycle with cyc low.
      for (int t = 0; t < 5; t++) begin
        a_s.ack = (t >= 1 && t <= 3);
        if (exp1) begin a_m1.stb = (t < 3); a_m1.cyc = (t < 4); end
        else      begin a_m0.stb = (t < 3); a_m0.cyc = (t < 4); end
        @(negedge clk);
        if (t == 0) begin
          checks++;
          if (a_s.addr !== exp_addr) begin
            errors++; $display("FAIL rr_grant_%0d: got addr %h expected %h", k, a_s.addr, exp_addr);
          end
          checks++;
          if ({a_m0.stall, a_m1.stall} !== exp_stalls) begin
            errors++; $display("FAIL rr_stalls_%0d: got %b expected %b", k, {a_m0.stall, a_m1.stall}, exp_stalls);
          end
        end
        if (a_m0.ack === 1'b1) acks0++;
        if (a_m1.ack === 1'b1) acks1++;
        tick();
      end
      checks++;
      if ((exp1 ? acks1 : acks0) != 3) begin
        errors++; $display("FAIL rr_owner_acks_%0d: got %0d expected 3", k, exp1 ? acks1 : acks0);
      end
      checks++;
      if ((exp1 ? acks0 : acks1) != 0) begin
        errors++; $display("FAIL rr_other_acks_%0d: got %0d expected 0", k, exp1 ? acks0 : acks1);
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_pipeline();
    int          exp_out [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    logic        exp_ack;
    logic        exp_full;
    logic [31:0] exp_data;
    do_reset();
    a_m1.cyc = 1;
    tick();
    // Four back-to-back strobes, each acked three cycles after acceptance.
    for (int t = 0; t < 8; t++) begin
      exp_ack     = (t >= 3) && (t <= 6);
      exp_data    = exp_ack ? 32'h0000_00A0 + 32'(t - 3) : 32'h0;
      a_m1.stb    = (t < 4);
      a_s.ack     = exp_ack;
      a_s.data_s  = exp_data;
      @(negedge clk);
      checks++;
      if (dut_a.outstanding_q !== 4'(exp_out[t])) begin
        errors++; $display("FAIL pipe_outstanding_%0d: got %0d expected %0d", t, dut_a.outstanding_q, exp_out[t]);
      end
      checks++;
      if (a_m1.ack !== exp_ack) begin
        errors++; $display("FAIL pipe_ack_%0d: got %b expected %b", t, a_m1.ack, exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (a_m1.data_s !== exp_data) begin
          errors++; $display("FAIL pipe_data_%0d: got %h expected %h", t, a_m1.data_s, exp_data);
        end
      end
      tick();
    end
    a_s.ack = 0; a_s.data_s = '0;
    // Unanswered strobes: the 16th must be held off by the outstanding limit.
    for (int j = 0; j < 16; j++) begin
      a_m1.stb = 1;
      exp_full = (j == 15);
      @(negedge clk);
      checks++;
      if ({a_m1.stall, a_s.stb} !== {exp_full, ~exp_full}) begin
        errors++; $display("FAIL pipe_limit_%0d: got stall/stb %b expected %b", j,
                           {a_m1.stall, a_s.stb}, {exp_full, ~exp_full});
      end
      tick();
    end
    a_m1.stb = 0; a_m1.cyc = 0;
    tick();
    a_s.ack = 1;
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m0.ack, a_m1.ack} !== 3'b000) begin
      errors++; $display("FAIL pipe_late_ack: got %b expected 000", {a_s.cyc, a_m0.ack, a_m1.ack});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    logic exp_err;
    do_reset();
    b_m0.cyc = 1; b_m0.stb = 1; b_m0.addr = 30'h40;
    tick();
    @(negedge clk);
    checks++;
    if ({b_s.cyc, b_s.stb, b_m0.stall} !== 3'b110) begin
      errors++; $display("FAIL wd_accept: got %b expected 110", {b_s.cyc, b_s.stb, b_m0.stall});
    end
    tick();
    b_m0.stb = 0;
    for (int t = 1; t <= 8; t++) begin
      exp_err = (t == 8);
      @(negedge clk);
      checks++;
      if ({b_m0.err, b_m0.ack} !== {exp_err, 1'b0}) begin
        errors++; $display("FAIL wd_err_%0d: got err/ack %b expected %b", t, {b_m0.err, b_m0.ack}, {exp_err, 1'b0});
      end
      tick();
    end
    b_s.ack = 1;
    @(negedge clk);
    checks++;
    if ({b_s.cyc, b_s.stb, b_m0.stall, b_m0.ack, b_m0.err} !== 5'b00100) begin
      errors++; $display("FAIL wd_abort: got %b expected 00100", {b_s.cyc, b_s.stb, b_m0.stall, b_m0.ack, b_m0.err});
    end
    tick();
    b_m0.cyc = 0;
    @(negedge clk);
    checks++;
    if ({b_s.cyc, b_m0.ack, b_m1.ack} !== 3'b000) begin
      errors++; $display("FAIL wd_abort_drop: got %b expected 000", {b_s.cyc, b_m0.ack, b_m1.ack});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({b_s.cyc, b_m0.ack, b_m1.ack, b_m0.stall} !== 4'b0001) begin
      errors++; $display("FAIL wd_idle_late_ack: got %b expected 0001", {b_s.cyc, b_m0.ack, b_m1.ack, b_m0.stall});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_m1.cyc = 1;
    tick();
    a_m1.stb = 1;
    tick();
    tick();
    a_m1.stb = 0; a_m0.cyc = 1; a_s.ack = 1; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_a.outstanding_q !== 4'd2) begin
      errors++; $display("FAIL rstmid_outstanding: got %0d expected 2", dut_a.outstanding_q);
    end
    tick();
    reset = 1'b0; a_s.ack = 0;
    @(negedge clk);
    checks++;
    if ({a_s.cyc, a_m0.stall, a_m1.stall, a_m0.ack, a_m1.ack} !== 5'b01100) begin
      errors++; $display("FAIL rstmid_idle: got %b expected 01100", {a_s.cyc, a_m0.stall, a_m1.stall, a_m0.ack, a_m1.ack});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({a_s.addr, a_m0.stall, a_m1.stall} !== {ADDR0, 2'b01}) begin
      errors++; $display("FAIL rstmid_regrant_m0: got addr=%h stalls=%b expected addr=%h stalls=01",
                         a_s.addr, {a_m0.stall, a_m1.stall}, ADDR0);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_pipeline();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master to one-slave pipelined Wishbone arbiter. Sits directly upstream of the slave-side multiplexer.
- Merges the CPU instruction master (m0) and the CPU data master (m1) onto the single master port that feeds the mux.
- Round-robin grant, held for a whole cycle (cyc high), with a bus-timeout watchdog that terminates hung transactions with err.

Parameters:
- DataWidth, 32, data bus width.
- AddrWidth, 30, word address width.
- SelWidth, DataWidth/8, byte-select width.
- TimeoutCycles, 255, stall-free wait cycles without ack/err before abort; 0 disables the watchdog.

Ports:
- clk  input  1  single clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_cyc, m1_cyc  input  1  master cycle request.
- m0_stb, m1_stb  input  1  master strobe.
- m0_we, m1_we  input  1  master write enable.
- m0_addr, m1_addr  input  AddrWidth  master address.
- m0_sel, m1_sel  input  SelWidth  master byte selects.
- m0_data_m, m1_data_m  input  DataWidth  master write data.
- m0_data_s, m1_data_s  output  DataWidth  read data to master.
- m0_ack, m1_ack / m0_err, m1_err  output  1  termination to master.
- m0_stall, m1_stall  output  1  stall to master.
- s_cyc, s_stb, s_we  output  1  to slave side.
- s_addr  output  AddrWidth  to slave side.
- s_sel  output  SelWidth  to slave side.
- s_data_m  output  DataWidth  to slave side.
- s_data_s  input  DataWidth  from slave side.
- s_ack, s_err, s_stall  input  1  from slave side.

Behaviour:
- State machine:
  - States: IDLE, GRANT0, GRANT1, ABORT (registered).
  - `last` register records the most recent grant.
  - Reset values: state=IDLE, last=1, outstanding=0, timer=0.
- IDLE outputs:
  - s_cyc=s_stb=s_we=0; s_addr, s_sel, s_data_m = 0.
  - All m*_ack=m*_err=0, m*_stall=1, m*_data_s=0.
- IDLE transitions:
  - Only m0_cyc -> GRANT0. Only m1_cyc -> GRANT1.
  - Both -> grant the master that is not `last`.
  - Grant latency is 1 cycle: the request is seen in cycle N and is visible on s_* in cycle N+1.
- GRANTx (combinational pass-through):
  - s_cyc/stb/we/addr/sel/data_m = mx_*.
  - mx_ack=s_ack, mx_err=s_err, mx_data_s=s_data_s.
  - mx_stall = s_stall OR (outstanding==15).
  - s_stb is gated off when outstanding==15.
  - The other master sees stall=1, ack=err=0, data_s=0.
- Leaving GRANTx:
  - When mx_cyc=0, s_cyc drops in the same cycle, `last`<=x, outstanding<=0, timer<=0.
  - Next state is GRANT(other) if the other master's cyc=1, else IDLE.
  - A master that drops cyc with outstanding>0 abandons those responses. Late ack/err are not forwarded to any master.
- Outstanding counter (4 bits):
  - +1 on s_stb & !s_stall (accepted request).
  - -1 on s_ack | s_err.
  - Both in the same cycle -> unchanged.
  - Never underflows: ack with outstanding==0 is ignored for counting but still forwarded.
- Watchdog:
  - timer counts while in GRANTx with outstanding>0 and no s_ack/s_err.
  - Clears on any ack/err, or when outstanding==0.
  - When timer reaches TimeoutCycles (nonzero), mx_err=1 for exactly that cycle (ack=0) and state -> ABORT.
- ABORT:
  - s_cyc=s_stb=0, mx_stall=1, mx_ack=mx_err=0.
  - Stays until mx_cyc=0, then updates `last` and re-arbitrates as in "Leaving GRANTx".
- Reset asserted mid-transaction: next cycle is IDLE with all outputs at reset values, regardless of pending ack.
- Grant never changes while the granted master holds cyc high. No preemption.

Test Plan:
- Single master: m0 one read, addr 0x10, slave acks 2 cycles after accept -> s_cyc high from cycle+1, m0_ack one cycle, m0_data_s=slave data 0xDEADBEEF, m1_stall=1 throughout, state back to IDLE.
- Simultaneous request right after reset: m0_cyc and m1_cyc both raised -> m0 granted first (last=1). When m0 drops cyc, GRANT1 follows on the next cycle with no IDLE gap.
- Round-robin fairness: both masters hold continuous back-to-back cycles of 3 transfers -> grants alternate 0,1,0,1; neither master is granted twice in a row.
- Pipelining: m1 issues 4 strobes with s_stall=0 and acks arrive 3 cycles later -> outstanding peaks at 3 then returns to 0, four m1_acks in order. Issue 15 strobes with no ack -> m1_stall forced high on the 16th.
- Watchdog: TimeoutCycles=8, m0 accepted request, slave never acks -> m0_err pulses exactly 8 cycles after acceptance, s_cyc=0 in the following cycle. m0 dropping cyc -> IDLE. A late s_ack is not forwarded.
- Reset mid-transfer: assert reset while GRANT1 with outstanding=2 -> next cycle s_cyc=0, all stalls=1, m0 is granted first after release if both masters request.
